flexdpe_psum_acc: RTL and testbench
===================================

FLEXDPE_PSUM_ACC -- requirements
Module: flexdpe_psum_acc

Interface
REQ-001 Parameter OUT_DATA_TYPE, default 24, SHALL set the width of each reduction-output lane in bits.
REQ-002 Parameter ACC_DATA_TYPE, default 32, SHALL set the width of each accumulator lane in bits; it SHALL be >= OUT_DATA_TYPE.
REQ-003 Parameter NUM_PES, default 16, SHALL set the lane count; parameter LOG2_PES, default 4, SHALL equal log2(NUM_PES).
REQ-004 Parameter LOG2_FOLDS, default 4, SHALL size the fold-count field; the maximum fold count is 2^LOG2_FOLDS.
REQ-005 Parameter FIFO_DEPTH, default 4 (power of 2), SHALL set the number of output result entries.
REQ-006 clk  input  1  sole clock; all state changes on its rising edge.
REQ-007 rst  input  1  reset; asynchronous assertion, active-low.
REQ-008 i_cfg_valid  input  1  config strobe; accepted only in IDLE.
REQ-009 i_cfg_folds  input  LOG2_FOLDS  fold count minus 1 (0 means 1 fold).
REQ-010 i_cfg_bypass  input  1  1 = every beat forwarded as-is, without accumulation.
REQ-011 i_stop  input  1  stop request; takes effect at the next group boundary.
REQ-012 i_data_valid  input  NUM_PES  per-lane valid from the FAN network.
REQ-013 i_data_bus  input  NUM_PES*OUT_DATA_TYPE  signed lane data; lane k is bits [k*OUT_DATA_TYPE +: OUT_DATA_TYPE].
REQ-014 o_data_ready  output  1  beat acceptance to upstream.
REQ-015 o_data_valid  output  NUM_PES  per-lane valid of the FIFO head.
REQ-016 o_data_bus  output  NUM_PES*ACC_DATA_TYPE  signed accumulated results.
REQ-017 i_data_ready  input  1  downstream pop enable.
REQ-018 o_busy  output  1  high in every state other than IDLE.
REQ-019 o_overflow  output  1  sticky saturation flag; cleared only by reset or by an accepted config.

Function
REQ-020 The state machine SHALL have the states IDLE, ACCUM and DRAIN.
REQ-021 IDLE->ACCUM SHALL occur on i_cfg_valid; folds, bypass and o_overflow=0 SHALL be latched on that edge.
REQ-022 A beat SHALL be a cycle with state==ACCUM, i_data_valid!=0 and o_data_ready=1; beats with i_data_valid==0 SHALL be ignored.
REQ-023 o_data_ready SHALL equal (state==ACCUM) AND (FIFO not full).
REQ-024 On the first beat of a group, lane k SHALL load sext(in_k) if valid_k and 0 otherwise; on later beats, valid lanes SHALL add sext(in_k) and invalid lanes SHALL hold.
REQ-025 Addition SHALL be signed and saturating to ACC_DATA_TYPE (max 2^(ACC-1)-1, min -2^(ACC-1)); any saturation SHALL set o_overflow.
REQ-026 A per-lane valid mask SHALL be the OR of i_data_valid over the group's beats.
REQ-027 The fold counter SHALL increment per beat; on the beat where the count equals the latched folds, it SHALL wrap to 0 and push {mask, acc-including-this-beat} into the FIFO.
REQ-028 In bypass mode, every beat SHALL be a complete group of 1 fold (latched folds ignored).
REQ-029 The result SHALL be visible on o_data_valid/o_data_bus exactly 1 cycle after the last beat, when the FIFO was empty.
REQ-030 A FIFO pop SHALL occur when o_data_valid!=0 and i_data_ready=1; a push and a pop in the same cycle SHALL both complete.
REQ-031 With the FIFO empty, o_data_valid and o_data_bus SHALL be 0.
REQ-032 i_stop SHALL be latched as stop_pend; at a group boundary (fold counter==0 after any push), if stop_pend then ACCUM->DRAIN and stop_pend SHALL clear.
REQ-033 i_stop asserted mid-group SHALL let the group complete before the DRAIN transition.
REQ-034 DRAIN->IDLE SHALL occur on the cycle the FIFO becomes empty.
REQ-035 In DRAIN, o_data_ready SHALL be 0.
REQ-036 i_cfg_valid outside IDLE SHALL be ignored.

Reset
REQ-037 While rst=0: state=IDLE, counters=0, accumulators=0, masks=0, FIFO empty, stop_pend=0, o_data_ready=0, o_data_valid=0, o_data_bus=0, o_busy=0, o_overflow=0.
REQ-038 Reset asserted mid-group or mid-drain SHALL discard all partial sums and FIFO contents, with no output pulse.

Structure
REQ-039 The package flexdpe_pkg SHALL hold the state encodings (IDLE=2'd0, ACCUM=2'd1, DRAIN=2'd2) and the saturation-limit constant functions.
REQ-040 The FIFO SHALL be the sub-module flexdpe_psum_fifo (width NUM_PES*(ACC_DATA_TYPE+1), depth FIFO_DEPTH, with full/empty flags).

Verification
REQ-041 Config folds=2 (3 folds); lane0 beats 5, -2, 10 -> one result lane0=13, o_data_valid=0x0001, 1 cycle after the 3rd beat.
REQ-042 Bypass; 4 beats with all lanes valid, i_data_ready=0 -> FIFO full after 4 beats, o_data_ready=0; 5th beat held; 1 pop -> ready returns, all 4 results in order.
REQ-043 ACC=32, folds=1; lane3 beats 0x7FFFFF twice with OUT=24, then force the accumulator near max (beats of max positive) -> result 0x7FFFFFFF, o_overflow=1 until next config.
REQ-044 folds=3; i_stop after beat 2 -> beats 3-4 accepted, result pushed, DRAIN, IDLE once popped; o_busy falls in the same cycle.
REQ-045 rst=0 asserted between beats 1 and 2 of a 2-fold group -> all outputs 0 immediately; after release, config folds=0 -> the fresh beat passes unaccumulated.

Source files
------------

// File: rtl/flexdpe_pkg.sv
// Shared state encoding and saturation-limit helpers for the FlexDPE partial-sum accumulator.
package flexdpe_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Bit patterns of the largest positive / most negative value of a signed width-bit word.
  function automatic logic [63:0] sat_max(input int unsigned width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int unsigned width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/flexdpe_psum_fifo.sv
// Result FIFO for the partial-sum accumulator; the head reads as zero whenever the FIFO is empty.
module flexdpe_psum_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/flexdpe_psum_acc.sv
// Per-lane saturating partial-sum accumulator: folds reduction-network beats into groups and queues results.
//
// state | meaning
// IDLE  | waiting for a config strobe
// ACCUM | accepting beats, pushing one result per completed group
// DRAIN | stop taken at a group boundary; emptying the result FIFO
module flexdpe_psum_acc import flexdpe_pkg::*; #(
  parameter int OUT_DATA_TYPE = 24,
  parameter int ACC_DATA_TYPE = 32,
  parameter int NUM_PES       = 16,
  parameter int LOG2_PES      = 4,
  parameter int LOG2_FOLDS    = 4,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_cfg_valid,
  input  logic [LOG2_FOLDS-1:0]            i_cfg_folds,
  input  logic                             i_cfg_bypass,
  input  logic                             i_stop,
  input  logic [NUM_PES-1:0]               i_data_valid,
  input  logic [NUM_PES*OUT_DATA_TYPE-1:0] i_data_bus,
  output logic                             o_data_ready,
  output logic [NUM_PES-1:0]               o_data_valid,
  output logic [NUM_PES*ACC_DATA_TYPE-1:0] o_data_bus,
  input  logic                             i_data_ready,
  output logic                             o_busy,
  output logic                             o_overflow
);

  localparam int OW    = OUT_DATA_TYPE;
  localparam int AW    = ACC_DATA_TYPE;
  localparam int LANES = 1 << LOG2_PES;
  localparam int FW    = NUM_PES * (AW + 1);
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [AW-1:0] ACC_MAX = AW'(sat_max(AW));
  localparam logic [AW-1:0] ACC_MIN = AW'(sat_min(AW));

  state_t                  state;
  state_t                  state_nxt;
  logic [LOG2_FOLDS-1:0]   folds_q;
  logic [LOG2_FOLDS-1:0]   fold_cnt;
  logic [LOG2_FOLDS-1:0]   fold_cnt_nxt;
  logic                    bypass_q;
  logic                    stop_pend;
  logic                    overflow_q;
  logic [NUM_PES*AW-1:0]   acc_q;
  logic [NUM_PES*AW-1:0]   acc_nxt;
  logic [NUM_PES-1:0]      mask_q;
  logic [NUM_PES-1:0]      mask_nxt;
  logic [NUM_PES-1:0]      lane_sat;
  logic                    beat;
  logic                    first;
  logic                    last;
  logic                    boundary;
  logic                    pop;
  logic                    drain_done;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [CW-1:0]           fifo_count;
  logic [FW-1:0]           fifo_head;

  assign beat         = o_data_ready && (i_data_valid != '0);
  assign first        = (fold_cnt == '0);
  assign last         = beat && (bypass_q || (fold_cnt == folds_q));
  assign fold_cnt_nxt = last ? '0 : (beat ? fold_cnt + 1'b1 : fold_cnt);
  assign boundary     = (fold_cnt_nxt == '0);
  assign mask_nxt     = first ? i_data_valid : (mask_q | i_data_valid);
  assign pop          = (o_data_valid != '0) && i_data_ready;
  assign drain_done   = fifo_empty || (pop && (fifo_count == CW'(1)));

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic signed [OW-1:0] din_raw;
    logic signed [AW-1:0] din;
    logic signed [AW-1:0] acc_cur;
    logic [AW:0]          sum;
    logic [AW-1:0]        lane_nxt;

    assign din_raw = i_data_bus[k*OW +: OW];
    assign din     = AW'(din_raw);
    assign acc_cur = acc_q[k*AW +: AW];
    // One guard bit: the top two sum bits disagree exactly when the signed add left the AW range.
    assign sum         = {acc_cur[AW-1], acc_cur} + {din[AW-1], din};
    assign lane_sat[k] = i_data_valid[k] && !first && (sum[AW] != sum[AW-1]);
    assign lane_nxt    = !i_data_valid[k] ? (first ? '0 : acc_cur)
                       : first            ? din
                       : lane_sat[k]      ? (sum[AW] ? ACC_MIN : ACC_MAX)
                       :                    sum[AW-1:0];
    assign acc_nxt[k*AW +: AW] = lane_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_cfg_valid) state_nxt = ACCUM;
      ACCUM:   if (stop_pend && boundary) state_nxt = DRAIN;
      DRAIN:   if (drain_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_data_ready = 1'b0;
    o_busy       = 1'b1;
    case (state)
      IDLE:    o_busy = 1'b0;
      ACCUM:   o_data_ready = !fifo_full;
      default: o_data_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      folds_q    <= '0;
      bypass_q   <= 1'b0;
      overflow_q <= 1'b0;
      stop_pend  <= 1'b0;
      fold_cnt   <= '0;
      acc_q      <= '0;
      mask_q     <= '0;
    end else begin
      if (state == IDLE && i_cfg_valid) begin
        folds_q    <= i_cfg_folds;
        bypass_q   <= i_cfg_bypass;
        overflow_q <= 1'b0;
      end
      if (beat) begin
        fold_cnt <= fold_cnt_nxt;
        acc_q    <= acc_nxt;
        mask_q   <= mask_nxt;
        if (lane_sat != '0) overflow_q <= 1'b1;
      end
      if (state == ACCUM && state_nxt == DRAIN) stop_pend <= 1'b0;
      else if (state == ACCUM && i_stop)        stop_pend <= 1'b1;
    end
  end

  // The pushed entry already includes the closing beat, so the result lands one cycle after it.
  flexdpe_psum_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (last),
    .push_data ({mask_nxt, acc_nxt}),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign o_data_valid = fifo_head[FW-1 -: NUM_PES];
  assign o_data_bus   = fifo_head[NUM_PES*AW-1:0];
  assign o_overflow   = overflow_q;

endmodule

// File: tb/tb_flexdpe_psum_acc.sv
// Scoreboard bench for flexdpe_psum_acc: a lane-sum reference model feeds expected results to a monitor.
module tb_flexdpe_psum_acc;

  localparam int NP = 16;
  localparam int OW = 24;
  localparam int AW = 32;
  localparam int LF = 9;
  localparam int FD = 4;
  localparam longint MAXV = (64'sd1 <<< (AW - 1)) - 64'sd1;
  localparam longint MINV = -(64'sd1 <<< (AW - 1));

  typedef struct packed {
    logic [NP-1:0]    mask;
    logic [NP*AW-1:0] bus;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              i_cfg_valid = 1'b0;
  logic [LF-1:0]     i_cfg_folds = '0;
  logic              i_cfg_bypass = 1'b0;
  logic              i_stop = 1'b0;
  logic [NP-1:0]     i_data_valid = '0;
  logic [NP*OW-1:0]  i_data_bus = '0;
  logic              o_data_ready;
  logic [NP-1:0]     o_data_valid;
  logic [NP*AW-1:0]  o_data_bus;
  logic              i_data_ready = 1'b0;
  logic              o_busy;
  logic              o_overflow;

  int     n_checks = 0;
  int     n_errors = 0;
  bit     rand_rdy = 1'b0;
  exp_t   sb[$];
  exp_t   mon_e;
  longint m_lane[NP];
  logic [NP-1:0] m_mask = '0;
  int     m_cnt = 0;
  int     m_folds = 0;
  bit     m_bypass = 1'b0;
  bit     m_ovf = 1'b0;

  always #5 clk = ~clk;

  flexdpe_psum_acc #(
    .OUT_DATA_TYPE (OW),
    .ACC_DATA_TYPE (AW),
    .NUM_PES       (NP),
    .LOG2_PES      (4),
    .LOG2_FOLDS    (LF),
    .FIFO_DEPTH    (FD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_cfg_valid  (i_cfg_valid),
    .i_cfg_folds  (i_cfg_folds),
    .i_cfg_bypass (i_cfg_bypass),
    .i_stop       (i_stop),
    .i_data_valid (i_data_valid),
    .i_data_bus   (i_data_bus),
    .o_data_ready (o_data_ready),
    .o_data_valid (o_data_valid),
    .o_data_bus   (o_data_bus),
    .i_data_ready (i_data_ready),
    .o_busy       (o_busy),
    .o_overflow   (o_overflow)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic chk_bus(input string name, input logic [NP*AW-1:0] act, input logic [NP*AW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Reference: each group sums its beats lane by lane with clamping; mask is the union of valids.
  task automatic model_beat(input logic [NP-1:0] v, input logic [NP*OW-1:0] d);
    exp_t e;
    for (int k = 0; k < NP; k++) begin
      logic signed [OW-1:0] raw;
      longint x;
      longint s;
      raw = d[k*OW +: OW];
      x = raw;
      if (m_cnt == 0) m_lane[k] = v[k] ? x : 0;
      else if (v[k]) begin
        s = m_lane[k] + x;
        if (s > MAXV) begin s = MAXV; m_ovf = 1'b1; end
        else if (s < MINV) begin s = MINV; m_ovf = 1'b1; end
        m_lane[k] = s;
      end
    end
    m_mask = (m_cnt == 0) ? v : (m_mask | v);
    m_cnt++;
    if (m_bypass || m_cnt > m_folds) begin
      e.mask = m_mask;
      for (int k = 0; k < NP; k++) e.bus[k*AW +: AW] = AW'(m_lane[k]);
      sb.push_back(e);
      m_cnt = 0;
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (o_data_valid != '0 && i_data_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_result: got valid=%h, required no result", o_data_valid);
        end else begin
          mon_e = sb.pop_front();
          chk("result_mask", 64'(o_data_valid), 64'(mon_e.mask));
          chk_bus("result_data", o_data_bus, mon_e.bus);
        end
      end else if (o_data_valid == '0) begin
        chk_bus("empty_bus_zero", o_data_bus, '0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NP*OW-1:0] rand_bus();
    logic [NP*OW-1:0] b;
    for (int k = 0; k < NP; k++) b[k*OW +: OW] = OW'($urandom);
    return b;
  endfunction

  function automatic logic [NP*OW-1:0] put_lane(input logic [NP*OW-1:0] b, input int lane,
                                                input logic [OW-1:0] val);
    logic [NP*OW-1:0] r;
    r = b;
    r[lane*OW +: OW] = val;
    return r;
  endfunction

  task automatic do_cfg(input int folds, input bit byp);
    i_cfg_valid  = 1'b1;
    i_cfg_folds  = LF'(folds);
    i_cfg_bypass = byp;
    tick();
    i_cfg_valid  = 1'b0;
    m_folds  = folds;
    m_bypass = byp;
    m_ovf    = 1'b0;
    m_cnt    = 0;
  endtask

  task automatic drive_beat(input logic [NP-1:0] v, input logic [NP*OW-1:0] d);
    int waited = 0;
    bit ok = 1'b0;
    i_data_valid = v;
    i_data_bus   = d;
    while (!ok && waited < 64) begin
      if (rand_rdy) i_data_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (o_data_ready) ok = 1'b1;
      else begin
        waited++;
        tick();
      end
    end
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL beat_accept: o_data_ready stayed 0 for %0d cycles, required 1", waited);
    end else begin
      model_beat(v, d);
    end
    tick();
    i_data_valid = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      i_data_valid = '0;
      i_data_bus   = rand_bus();
      if (rand_rdy) i_data_ready = 1'($urandom_range(0, 1));
      tick();
    end
  endtask

  task automatic finish_run(input string name);
    int waited = 0;
    rand_rdy     = 1'b0;
    i_data_ready = 1'b1;
    i_stop       = 1'b1;
    tick();
    i_stop       = 1'b0;
    while (o_busy && waited < 64) begin
      tick();
      waited++;
    end
    chk({name, "_idle"}, 64'(o_busy), 64'd0);
    chk({name, "_drained"}, 64'(sb.size()), 64'd0);
    chk({name, "_overflow"}, 64'(o_overflow), 64'(m_ovf));
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_ready"}, 64'(o_data_ready), 64'd0);
    chk({name, "_valid"}, 64'(o_data_valid), 64'd0);
    chk_bus({name, "_bus"}, o_data_bus, '0);
    chk({name, "_busy"}, 64'(o_busy), 64'd0);
    chk({name, "_overflow"}, 64'(o_overflow), 64'd0);
  endtask

  initial begin
    logic [NP*OW-1:0] d;
    logic [NP-1:0]    v;
    int               folds;
    int               nbeats;
    bit               byp;

    #12;
    check_all_zero("reset");
    @(posedge clk);
    #1 rst = 1'b1;
    tick();

    // Three folds on lane 0 only, with a config strobe mid-group that must be ignored.
    i_data_ready = 1'b1;
    do_cfg(2, 1'b0);
    drive_beat(16'h0001, put_lane(rand_bus(), 0, OW'(5)));
    i_cfg_valid = 1'b1; i_cfg_folds = '0; i_cfg_bypass = 1'b1;
    tick();
    i_cfg_valid = 1'b0;
    drive_beat(16'h0001, put_lane(rand_bus(), 0, OW'(-2)));
    idle(1);
    drive_beat(16'h0001, put_lane(rand_bus(), 0, OW'(10)));
    @(negedge clk);
    chk("fold3_latency_valid", 64'(o_data_valid), 64'h0001);
    chk("fold3_lane0", 64'(o_data_bus[31:0]), 64'd13);
    tick();
    finish_run("fold3");

    // Bypass with a stalled consumer: four results fill the FIFO, the fifth beat waits.
    i_data_ready = 1'b0;
    do_cfg(5, 1'b1);
    for (int b = 0; b < 4; b++) drive_beat('1, rand_bus());
    d = rand_bus();
    i_data_valid = '1;
    i_data_bus   = d;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("full_ready_low", 64'(o_data_ready), 64'd0);
      tick();
    end
    i_data_ready = 1'b1;
    drive_beat('1, d);
    finish_run("bypass_full");

    // Positive and negative saturation over a long group; overflow sticks until the next config.
    do_cfg(1, 1'b0);
    drive_beat(16'h0008, put_lane(rand_bus(), 3, 24'h7FFFFF));
    drive_beat(16'h0008, put_lane(rand_bus(), 3, 24'h7FFFFF));
    finish_run("sat_small");
    do_cfg(299, 1'b0);
    for (int b = 0; b < 300; b++)
      drive_beat(16'h000C, put_lane(put_lane(rand_bus(), 3, 24'h7FFFFF), 2, 24'h800000));
    @(negedge clk);
    chk("sat_pos_lane3", 64'(o_data_bus[3*AW +: AW]), 64'h7FFF_FFFF);
    chk("sat_neg_lane2", 64'(o_data_bus[2*AW +: AW]), 64'h8000_0000);
    chk("sat_overflow_set", 64'(o_overflow), 64'd1);
    tick();
    finish_run("sat_big");
    do_cfg(0, 1'b0);
    chk("overflow_cleared", 64'(o_overflow), 64'd0);
    finish_run("after_sat");

    // Stop in the middle of a four-fold group: group completes, then drain.
    i_data_ready = 1'b0;
    do_cfg(3, 1'b0);
    for (int b = 0; b < 2; b++) begin
      v = NP'($urandom);
      if (v == '0) v = 16'h0001;
      drive_beat(v, rand_bus());
    end
    i_stop = 1'b1;
    tick();
    i_stop = 1'b0;
    for (int b = 0; b < 2; b++) begin
      v = NP'($urandom);
      if (v == '0) v = 16'h8000;
      drive_beat(v, rand_bus());
    end
    @(negedge clk);
    chk("stop_busy", 64'(o_busy), 64'd1);
    chk("stop_result_present", 64'(o_data_valid != '0), 64'd1);
    tick();
    tick();
    @(negedge clk);
    chk("drain_ready_low", 64'(o_data_ready), 64'd0);
    tick();
    i_data_ready = 1'b1;
    tick();
    chk("drain_busy_fall", 64'(o_busy), 64'd0);
    chk("drain_valid_zero", 64'(o_data_valid), 64'd0);
    chk("drain_sb_empty", 64'(sb.size()), 64'd0);

    // Reset with a queued result and a half-built group, then a fresh single-fold config.
    i_data_ready = 1'b0;
    do_cfg(1, 1'b0);
    drive_beat('1, rand_bus());
    drive_beat('1, rand_bus());
    drive_beat(16'h0001, put_lane(rand_bus(), 0, OW'(7)));
    @(negedge clk);
    chk("pre_reset_valid", 64'(o_data_valid), 64'hFFFF);
    #2 rst = 1'b0;
    #1 check_all_zero("mid_reset");
    sb.delete();
    m_cnt = 0;
    m_ovf = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    i_data_ready = 1'b1;
    do_cfg(0, 1'b0);
    drive_beat(16'h0001, put_lane(rand_bus(), 0, OW'(9)));
    @(negedge clk);
    chk("post_reset_fresh", 64'(o_data_bus[31:0]), 64'd9);
    tick();
    finish_run("post_reset");

    // Randomized runs: folds, bypass, lane masks, data, gaps and consumer back-pressure.
    for (int r = 0; r < 8; r++) begin
      folds  = $urandom_range(0, 7);
      byp    = ($urandom_range(0, 3) == 0);
      nbeats = byp ? $urandom_range(1, 8) : (folds + 1) * $urandom_range(1, 3);
      do_cfg(folds, byp);
      rand_rdy = 1'b1;
      for (int b = 0; b < nbeats; b++) begin
        if ($urandom_range(0, 3) == 0) idle(1);
        v = NP'($urandom) & NP'($urandom);
        if (v == '0) v = NP'(1) << $urandom_range(0, NP - 1);
        drive_beat(v, rand_bus());
      end
      finish_run("random");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    n_errors++;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
